ripple_count_sampler: RTL

Synchronous consumer for the 4-bit ripple counter output. It samples the asynchronous, glitch-prone count bus into the `clk` domain and accepts only stable values. It accumulates the modulo-16 increments over fixed measurement windows and delivers each window's event total through a valid/ready handshake. It sits directly downstream of the ripple counter and turns its free-running count into per-window event totals for the control logic.

---
 rtl/ripple_count_sampler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ripple_count_sampler.sv
// Samples a free-running ripple count into the clk domain, filters glitches,
// and reports per-window event totals through a valid/ready handshake.
module ripple_count_sampler #(
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned PERIOD = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] q_async,
    input  logic             en,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             overrun,
    output logic             sat
);

    localparam int unsigned WIN_W = $clog2(PERIOD);
    localparam int unsigned SUM_W = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_s1;
    logic [CNT_W-1:0]   r_s2;
    logic [CNT_W-1:0]   r_stable_q;
    logic [CNT_W-1:0]   r_last_q;
    logic [WIN_W-1:0]   r_win_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic               r_sat_w;

    logic [CNT_W-1:0]   w_delta;
    logic [SUM_W-1:0]   w_sum;
    logic               w_ovf;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_sat_next;
    logic               w_win_end;

    always_comb begin
        w_delta    = r_stable_q - r_last_q;
        w_sum      = SUM_W'(r_acc) + SUM_W'(w_delta);
        w_ovf      = (w_sum[SUM_W-1:ACC_W] != '0);
        w_acc_next = w_ovf ? '1 : w_sum[ACC_W-1:0];
        w_sat_next = r_sat_w | w_ovf;
        w_win_end  = (r_state == RUN) && en && (r_win_cnt == WIN_LAST);
    end

    // r_s1 == r_s2 means the same value was sampled on two consecutive edges,
    // so a single-cycle glitch can never reach r_stable_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_stable_q <= '0;
        end else begin
            r_s1 <= q_async;
            r_s2 <= r_s1;
            if (r_s1 == r_s2) begin
                r_stable_q <= r_s2;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_last_q  <= '0;
            r_win_cnt <= '0;
            r_acc     <= '0;
            r_sat_w   <= 1'b0;
            acc_out   <= '0;
            acc_valid <= 1'b0;
            overrun   <= 1'b0;
            sat       <= 1'b0;
        end else begin
            overrun <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_win_cnt <= '0;
                    r_acc     <= '0;
                    r_sat_w   <= 1'b0;
                    if (en) begin
                        r_state <= ARM;
                    end
                end
                ARM: begin
                    if (!en) begin
                        r_state <= IDLE;
                    end else begin
                        r_last_q <= r_stable_q;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        r_state   <= IDLE;
                        r_win_cnt <= '0;
                        r_acc     <= '0;
                        r_sat_w   <= 1'b0;
                    end else begin
                        r_last_q <= r_stable_q;
                        if (w_win_end) begin
                            r_win_cnt <= '0;
                            r_acc     <= '0;
                            r_sat_w   <= 1'b0;
                        end else begin
                            r_win_cnt <= r_win_cnt + WIN_W'(1);
                            r_acc     <= w_acc_next;
                            r_sat_w   <= w_sat_next;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // A result only claims the slot if it is empty or being drained this edge.
            if (w_win_end) begin
                if (!acc_valid || acc_ready) begin
                    acc_out   <= w_acc_next;
                    sat       <= w_sat_next;
                    acc_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (acc_valid && acc_ready) begin
                acc_valid <= 1'b0;
            end
        end
    end

endmodule
